// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing and test-pattern source for the HDMI/TMDS encoder, pixel clock domain.
//   Ports:
//     pixclk       in   pixel clock
//     rst          in   synchronous active-high reset
//     mode         in   pattern select (0 solid, 1 bars, 2 gradient, 3 grid),
//                       sampled only at pixel (0,0)
//     solid_rgb    in   {r,g,b} for mode 0, sampled only at pixel (0,0)
//     hSync/vSync  out  syncs, active level set by HS_POL/VS_POL
//     DrawArea     out  active-video flag
//     red/green/blue out pixel colour, zero outside the active area
//     x, y         out  position of the pixel currently on the outputs
//     frame_start  out  one-cycle pulse alongside pixel (0,0)
//   All outputs are registered and mutually aligned, one cycle behind the counters.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int GRID     = 32,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic                   pixclk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   hSync,
  output logic                   vSync,
  output logic                   DrawArea,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic [HW-1:0]          x,
  output logic [VW-1:0]          y,
  output logic                   frame_start
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int GW    = (GRID > 1) ? $clog2(GRID) : 1;
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Raster position and pattern sub-counters
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic [VW-1:0]          vcnt_q, vcnt_d;
  logic [BW-1:0]          bar_cnt_q, bar_cnt_d;
  logic [2:0]             bar_idx_q, bar_idx_d;
  logic [GW-1:0]          gx_q, gx_d;
  logic [GW-1:0]          gy_q, gy_d;
  logic [1:0]             mode_q, mode_d;
  logic [3*COLOR_W-1:0]   solid_q, solid_d;

  // Registered outputs
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   da_q, da_d;
  logic [3*COLOR_W-1:0]   rgb_q, rgb_d;
  logic [HW-1:0]          x_q;
  logic [VW-1:0]          y_q;
  logic                   fs_q, fs_d;

  logic                   h_last_s, v_last_s, origin_s, active_s;
  logic [2:0]             bar_bits_s;
  logic [COLOR_W-1:0]     grad_s;

  // Next-state for the raster counters, sub-counters and frame-boundary latches
  always_comb begin
    h_last_s  = (hcnt_q == HW'(H_TOTAL - 1));
    v_last_s  = (vcnt_q == VW'(V_TOTAL - 1));
    origin_s  = (hcnt_q == HW'(0)) && (vcnt_q == VW'(0));
    hcnt_d    = h_last_s ? HW'(0) : hcnt_q + HW'(1);
    vcnt_d    = vcnt_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    gx_d      = gx_q;
    gy_d      = gy_q;

    if (h_last_s) begin
      vcnt_d = v_last_s ? VW'(0) : vcnt_q + VW'(1);
    end else begin
      vcnt_d = vcnt_q;
    end

    // Bar index steps every BAR_W pixels and parks on black (7) past the last bar.
    if (h_last_s) begin
      bar_cnt_d = BW'(0);
      bar_idx_d = 3'd0;
    end else if (bar_cnt_q == BW'(BAR_W - 1)) begin
      bar_cnt_d = BW'(0);
      bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
    end else begin
      bar_cnt_d = bar_cnt_q + BW'(1);
    end

    // Per-axis modulo-GRID counters replace x % GRID and y % GRID.
    if (h_last_s || (gx_q == GW'(GRID - 1))) begin
      gx_d = GW'(0);
    end else begin
      gx_d = gx_q + GW'(1);
    end

    if (h_last_s) begin
      if (v_last_s || (gy_q == GW'(GRID - 1))) begin
        gy_d = GW'(0);
      end else begin
        gy_d = gy_q + GW'(1);
      end
    end else begin
      gy_d = gy_q;
    end

    // The pixel at (0,0) already uses the freshly sampled mode and colour.
    if (origin_s) begin
      mode_d  = mode;
      solid_d = solid_rgb;
    end else begin
      mode_d  = mode_q;
      solid_d = solid_q;
    end
  end

  // Decode of the current counter state into the next output word
  always_comb begin
    active_s   = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    hs_d       = ((hcnt_q >= HS_START) && (hcnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vs_d       = ((vcnt_q >= VS_START) && (vcnt_q < VS_END)) ? VS_POL : ~VS_POL;
    da_d       = active_s;
    fs_d       = origin_s;
    grad_s     = COLOR_W'(hcnt_q);
    bar_bits_s = 3'b000;
    rgb_d      = {(3*COLOR_W){1'b0}};

    // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
    case (bar_idx_q)
      3'd0:    bar_bits_s = 3'b111;
      3'd1:    bar_bits_s = 3'b110;
      3'd2:    bar_bits_s = 3'b011;
      3'd3:    bar_bits_s = 3'b010;
      3'd4:    bar_bits_s = 3'b101;
      3'd5:    bar_bits_s = 3'b100;
      3'd6:    bar_bits_s = 3'b001;
      default: bar_bits_s = 3'b000;
    endcase

    case (mode_d)
      2'd0:    rgb_d = solid_d;
      2'd1:    rgb_d = {{COLOR_W{bar_bits_s[2]}}, {COLOR_W{bar_bits_s[1]}},
                        {COLOR_W{bar_bits_s[0]}}};
      2'd2:    rgb_d = {grad_s, grad_s, grad_s};
      2'd3:    rgb_d = ((gx_q == GW'(0)) || (gy_q == GW'(0))) ?
                       {(3*COLOR_W){1'b1}} : {(3*COLOR_W){1'b0}};
      default: rgb_d = {(3*COLOR_W){1'b0}};
    endcase

    if (!active_s) begin
      rgb_d = {(3*COLOR_W){1'b0}};
    end else begin
      rgb_d = rgb_d;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge pixclk) begin
    if (rst) begin
      hcnt_q    <= HW'(0);
      vcnt_q    <= VW'(0);
      bar_cnt_q <= BW'(0);
      bar_idx_q <= 3'd0;
      gx_q      <= GW'(0);
      gy_q      <= GW'(0);
      mode_q    <= 2'd1;
      solid_q   <= {(3*COLOR_W){1'b0}};
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      da_q      <= 1'b0;
      rgb_q     <= {(3*COLOR_W){1'b0}};
      x_q       <= HW'(0);
      y_q       <= VW'(0);
      fs_q      <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      da_q      <= da_d;
      rgb_q     <= rgb_d;
      x_q       <= hcnt_q;
      y_q       <= vcnt_q;
      fs_q      <= fs_d;
    end
  end

  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign DrawArea    = da_q;
  assign red         = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign green       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign blue        = rgb_q[COLOR_W-1:0];
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 24x8 raster (16x4 active).
module tb_video_timing_gen;

  logic        pixclk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd1;
  logic [23:0] solid_rgb = 24'h000000;
  logic        hSync, vSync, DrawArea, frame_start;
  logic [7:0]  red, green, blue;
  logic [4:0]  x;
  logic [2:0]  y;
  logic [23:0] rgb_s;

  int checks = 0;
  int passes = 0;
  int pos = -1;             // index of the pixel on the outputs since the last reset release
  logic [1:0]  lat_mode = 2'd1;

  assign rgb_s = {red, green, blue};

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(8), .GRID(4)
  ) dut (
    .pixclk(pixclk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .hSync(hSync), .vSync(vSync), .DrawArea(DrawArea),
    .red(red), .green(green), .blue(blue),
    .x(x), .y(y), .frame_start(frame_start)
  );

  always #5 pixclk = ~pixclk;

  // Hand-written pattern reference for the 16x4 active area.
  function automatic logic [23:0] exp_rgb(input logic [1:0] m, input int sx, input int sy,
                                          input logic [23:0] s);
    logic [7:0] g;
    g = 8'(sx);
    if (sx >= 16 || sy >= 4) return 24'h000000;
    case (m)
      2'd0: return s;
      2'd1: begin
        case (sx / 2)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'd2: return {g, g, g};
      default: return ((sx % 4 == 0) || (sy % 4 == 0)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic tick();
    logic [1:0] m;
    m = mode;
    @(posedge pixclk);
    #1;
    pos++;
    if (pos >= 0 && pos % 192 == 0) lat_mode = m;
  endtask

  task automatic advance_to(input int tx, input int ty);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!((pos % 24) == tx && ((pos / 24) % 8) == ty) && n < 400);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({hSync, vSync, DrawArea, frame_start, rgb_s, x, y} !== {1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 5'd0, 3'd0})
        $display("FAIL reset_hold cyc=%0d got hs=%b vs=%b da=%b fs=%b rgb=%h x=%0d y=%0d",
                 i, hSync, vSync, DrawArea, frame_start, rgb_s, x, y);
      else passes++;
    end
    rst = 1'b0;
    pos = -1;
    tick();
    checks++;
    if ({frame_start, DrawArea, x, y} !== {1'b1, 1'b1, 5'd0, 3'd0})
      $display("FAIL reset_release got fs=%b da=%b x=%0d y=%0d exp fs=1 da=1 x=0 y=0",
               frame_start, DrawArea, x, y);
    else passes++;
    checks++;
    if (rgb_s !== 24'hFFFFFF) $display("FAIL reset_first_rgb got=%h exp=ffffff", rgb_s);
    else passes++;
  endtask

  // Full frame in bars mode: every output against the raster model.
  task automatic test_frame_timing();
    int da_cnt, fs_at, fs_cnt, px, py;
    da_cnt = 0; fs_at = -1; fs_cnt = 0;
    for (int i = 1; i <= 192; i++) begin
      tick();
      px = pos % 24;
      py = (pos / 24) % 8;
      if (DrawArea === 1'b1) da_cnt++;
      if (frame_start === 1'b1) begin fs_cnt++; fs_at = i; end
      checks++;
      if (DrawArea !== (px < 16 && py < 4)) $display("FAIL drawarea pos=%0d got=%b", pos, DrawArea);
      else passes++;
      checks++;
      if (hSync !== !(px >= 18 && px <= 20)) $display("FAIL hsync x=%0d y=%0d got=%b", px, py, hSync);
      else passes++;
      checks++;
      if (vSync !== (py == 5 || py == 6)) $display("FAIL vsync x=%0d y=%0d got=%b", px, py, vSync);
      else passes++;
      checks++;
      if (x !== 5'(px) || y !== 3'(py))
        $display("FAIL position got x=%0d y=%0d exp x=%0d y=%0d", x, y, px, py);
      else passes++;
      checks++;
      if (rgb_s !== exp_rgb(2'd1, px, py, 24'h0))
        $display("FAIL bars x=%0d y=%0d got=%h exp=%h", px, py, rgb_s, exp_rgb(2'd1, px, py, 24'h0));
      else passes++;
    end
    checks++;
    if (da_cnt !== 64) $display("FAIL drawarea_count got=%0d exp=64", da_cnt);
    else passes++;
    checks++;
    if (fs_cnt !== 1 || fs_at !== 192)
      $display("FAIL frame_period got count=%0d at=%0d exp count=1 at=192", fs_cnt, fs_at);
    else passes++;
  endtask

  task automatic test_gradient();
    mode = 2'd2;
    advance_to(0, 0);
    advance_to(5, 0);
    checks++;
    if (rgb_s !== 24'h050505) $display("FAIL grad_x5 got=%h exp=050505", rgb_s);
    else passes++;
    advance_to(15, 0);
    checks++;
    if (rgb_s !== 24'h0F0F0F) $display("FAIL grad_x15 got=%h exp=0f0f0f", rgb_s);
    else passes++;
    tick();
    checks++;
    if (rgb_s !== 24'h000000 || DrawArea !== 1'b0)
      $display("FAIL grad_blank got=%h da=%b exp=000000 da=0", rgb_s, DrawArea);
    else passes++;
    advance_to(3, 1);
    checks++;
    if (rgb_s !== 24'h030303) $display("FAIL grad_x3y1 got=%h exp=030303", rgb_s);
    else passes++;
  endtask

  task automatic test_grid();
    int bad;
    mode = 2'd3;
    advance_to(0, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (rgb_s !== 24'hFFFFFF) bad++;
      if (i < 15) tick();
    end
    checks++;
    if (bad !== 0) $display("FAIL grid_row0 got %0d non-white pixels exp 0", bad);
    else passes++;
    advance_to(4, 1);
    checks++;
    if (rgb_s !== 24'hFFFFFF) $display("FAIL grid_x4y1 got=%h exp=ffffff", rgb_s);
    else passes++;
    tick();
    checks++;
    if (rgb_s !== 24'h000000) $display("FAIL grid_x5y1 got=%h exp=000000", rgb_s);
    else passes++;
    advance_to(0, 3);
    checks++;
    if (rgb_s !== 24'hFFFFFF) $display("FAIL grid_x0y3 got=%h exp=ffffff", rgb_s);
    else passes++;
    advance_to(7, 3);
    checks++;
    if (rgb_s !== 24'h000000) $display("FAIL grid_x7y3 got=%h exp=000000", rgb_s);
    else passes++;
  endtask

  task automatic test_mode_defer();
    int bad_old, bad_new, px, py;
    mode = 2'd1;
    advance_to(0, 0);
    advance_to(0, 2);
    mode = 2'd0;
    solid_rgb = 24'h123456;
    bad_old = 0;
    while (pos % 192 != 191) begin
      tick();
      px = pos % 24;
      py = (pos / 24) % 8;
      if (rgb_s !== exp_rgb(2'd1, px, py, 24'h0)) bad_old++;
    end
    checks++;
    if (bad_old !== 0) $display("FAIL defer_bars got %0d wrong pixels exp 0", bad_old);
    else passes++;
    bad_new = 0;
    for (int i = 0; i < 192; i++) begin
      tick();
      px = pos % 24;
      py = (pos / 24) % 8;
      if (rgb_s !== ((px < 16 && py < 4) ? 24'h123456 : 24'h000000)) bad_new++;
    end
    checks++;
    if (bad_new !== 0) $display("FAIL defer_solid got %0d wrong pixels exp 0", bad_new);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    int fs_cnt;
    advance_to(10, 2);
    checks++;
    if (x !== 5'd10 || y !== 3'd2) $display("FAIL mid_pos got x=%0d y=%0d exp x=10 y=2", x, y);
    else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({hSync, vSync, DrawArea, frame_start, rgb_s, x, y} !== {1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 5'd0, 3'd0})
      $display("FAIL mid_reset got hs=%b vs=%b da=%b fs=%b rgb=%h x=%0d y=%0d",
               hSync, vSync, DrawArea, frame_start, rgb_s, x, y);
    else passes++;
    pos = -1;
    tick();
    checks++;
    if ({frame_start, DrawArea, x, y, rgb_s} !== {1'b1, 1'b1, 5'd0, 3'd0, 24'h123456})
      $display("FAIL mid_restart got fs=%b da=%b x=%0d y=%0d rgb=%h exp fs=1 da=1 x=0 y=0 rgb=123456",
               frame_start, DrawArea, x, y, rgb_s);
    else passes++;
    fs_cnt = 0;
    for (int i = 1; i < 192; i++) begin
      tick();
      if (frame_start === 1'b1) fs_cnt++;
    end
    tick();
    checks++;
    if (fs_cnt !== 0 || frame_start !== 1'b1)
      $display("FAIL mid_next_frame got early=%0d fs=%b exp early=0 fs=1", fs_cnt, frame_start);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_gradient();
    test_grid();
    test_mode_defer();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised video timing and test-pattern source that replaces the fixed-mode video generator feeding the HDMI/TMDS encoder. It counts pixel and line positions for an arbitrary raster, drives hSync/vSync/DrawArea with configurable polarity, and produces one of four RGB test patterns. Pattern changes take effect only at frame boundaries. It runs in the pixel clock domain and connects directly to the HDMI encoder's hSync/vSync/DrawArea/red/green/blue inputs.

## Interface
- H_ACTIVE, 640, visible pixels per line (≥8)
- H_FP, 16, horizontal front porch, pixels (≥1)
- H_SYNC, 96, horizontal sync width, pixels (≥1)
- H_BP, 48, horizontal back porch, pixels (≥1)
- V_ACTIVE, 480, visible lines per frame (≥1)
- V_FP, 10, vertical front porch, lines (≥1)
- V_SYNC, 2, vertical sync width, lines (≥1)
- V_BP, 33, vertical back porch, lines (≥1)
- HS_POL, 0, hSync active level (1 = active-high)
- VS_POL, 0, vSync active level (1 = active-high)
- COLOR_W, 8, bits per colour channel
- GRID, 32, grid pitch, pixels/lines (≥2)
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; counter widths = clog2(total); BAR_W = H_ACTIVE/8 (integer)
- pixclk  in  1  pixel clock; only clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 gradient, 3 grid
- solid_rgb  in  3*COLOR_W  {r,g,b} for mode 0
- hSync  out  1  horizontal sync
- vSync  out  1  vertical sync
- DrawArea  out  1  active-video flag
- red, green, blue  out  COLOR_W each  pixel colour
- x, y  out  counter width  position of the pixel currently on the outputs
- frame_start  out  1  one-cycle pulse with pixel (0,0)

## Operation
- hcnt runs 0..H_TOTAL-1, wraps to 0; on wrap, vcnt increments, wrapping V_TOTAL-1 -> 0.
- Active: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- hSync asserted (level HS_POL) for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); otherwise inactive (~HS_POL).
- vSync asserted (level VS_POL) for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) for every pixel of those lines; otherwise inactive.
- Mode/solid latch: mode and solid_rgb captured into internal registers only on the cycle counters equal (0,0); changes at any other time are deferred to the next frame. Reset loads mode 1 (bars), solid 0.
- Patterns (outside active area rgb = 0 in all modes):
  - 0: rgb = latched solid_rgb.
  - 1: 8 bars, order white, yellow, cyan, green, magenta, red, blue, black; full = all ones. Bar index from a sub-counter advancing every BAR_W pixels, saturating at 7 (remainder pixels stay black). No dividers.
  - 2: red = green = blue = x[COLOR_W-1:0] (wraps).
  - 3: white where x mod GRID == 0 or y mod GRID == 0, else black; use per-axis modulo counters, no dividers.
- frame_start = 1 exactly for the output cycle showing (0,0).

## Timing
- Counters are the only state feeding decode; all outputs registered: outputs at edge N+1 reflect counter state at edge N (latency 1). All outputs mutually aligned.
- Reset (synchronous, any cycle including mid-frame): counters -> (0,0); hSync = ~HS_POL, vSync = ~VS_POL, DrawArea = 0, rgb = 0, x = y = 0, frame_start = 0. First cycle after rst deasserts: counters at (0,0), mode latched; next edge outputs show pixel (0,0) with frame_start = 1.
- Held rst: outputs stay at reset values.
- Horizontal wrap and vertical increment occur on the same edge; no dead cycle between lines or frames.
- Sub-counters (bar, grid) reset at hcnt = 0 and vcnt = 0 respectively.

## Test plan
Bench params: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); COLOR_W=8, GRID=4.
- Reset release -> frame_start at first output cycle, next frame_start exactly 192 cycles later; DrawArea high 16 of every 24 cycles on lines 0–3, 64 cycles/frame total.
- HS_POL=0 -> hSync low for x=18..20 on every line; VS_POL=1 -> vSync high for all 48 cycles of lines 5–6, low elsewhere.
- mode=1 -> x=0,1 white (FFFFFF), x=2,3 yellow (FFFF00), …, x=14,15 black; blanking rgb = 0.
- mode=2 -> rgb at x=5 equals 050505; mode=3 -> x=4,y=1 white, x=5,y=1 black, y=0 all white.
- mode changed 1->0 with solid_rgb=123456 at line 2 -> bars continue to frame end; next frame shows 123456 on all active pixels.
- rst asserted 1 cycle at x=10, y=2 -> next output cycle at reset values, then (0,0) with frame_start = 1.
